// File: rtl/nx_node_arbiter_pkg.sv
// Shared node message definitions used by the mesh node datapath.
// node_message_t is the single-beat unit carried between node blocks.
package NXConstants;

  localparam int MESSAGE_WIDTH = 32;

  typedef struct packed {
    logic [3:0]  row;
    logic [3:0]  column;
    logic [1:0]  command;
    logic [21:0] payload;
  } node_message_t;

endpackage

// File: rtl/nx_arbiter_rr.sv
// Combinational round-robin picker: first requester at or after ptr,
// wrapping modulo STREAMS so non-power-of-2 counts work.
module nx_arbiter_rr #(
  parameter int STREAMS = 4,
  parameter int PTR_W   = $clog2(STREAMS)
) (
  input  logic [STREAMS-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [STREAMS-1:0] grant,
  output logic [PTR_W-1:0]   idx
);

  int               sum;
  logic [PTR_W-1:0] k;
  logic             found;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    sum   = 0;
    k     = '0;
    for (int off = 0; off < STREAMS; off++) begin
      sum = int'(ptr) + off;
      if (sum >= STREAMS) sum = sum - STREAMS;
      k = PTR_W'(sum);
      if (!found && req[k]) begin
        found    = 1'b1;
        grant[k] = 1'b1;
        idx      = k;
      end
    end
  end

endmodule

// File: rtl/nx_node_arbiter.sv
// Round-robin message arbiter feeding a node's outbound distributor through a
// one-entry holding register. Define NX_ARB_PRIORITY_EN for source-0 priority
// with starvation override of sources 1..STREAMS-1.
module nx_node_arbiter
  import NXConstants::*;
#(
  parameter int STREAMS      = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                                  i_clk,
  input  logic                                  i_rst,
  output logic                                  o_idle,
  input  logic [STREAMS-1:0][MESSAGE_WIDTH-1:0] i_inbound_data,
  input  logic [STREAMS-1:0]                    i_inbound_valid,
  output logic [STREAMS-1:0]                    o_inbound_ready,
  output logic [MESSAGE_WIDTH-1:0]              o_outbound_data,
  output logic                                  o_outbound_valid,
  input  logic                                  i_outbound_ready
);

  localparam int PTR_W    = $clog2(STREAMS);
  localparam int STARVE_W = 8;

  if (STREAMS < 2 || STREAMS > 8 || STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_bad_param
    $error("nx_node_arbiter: parameter out of range");
  end

  // Handshakes: a beat moves on a port only in a cycle where its valid and
  // ready are both high at the rising edge; valid never waits on ready.
  logic             hold_valid;
  node_message_t    hold_data;
  logic [PTR_W-1:0] rr_ptr;
  logic             load;
  logic [STREAMS-1:0] rr_req, rr_grant, sel, grant;
  logic [PTR_W-1:0]   rr_idx, sel_idx;
  logic               ptr_move, any_grant;

  nx_arbiter_rr #(.STREAMS(STREAMS), .PTR_W(PTR_W)) u_rr (
    .req   (rr_req),
    .ptr   (rr_ptr),
    .grant (rr_grant),
    .idx   (rr_idx)
  );

`ifdef NX_ARB_PRIORITY_EN
  logic [STARVE_W-1:0] starve_cnt [STREAMS-1:1];
  logic [STREAMS-1:0]  starved;

  assign rr_req = i_inbound_valid & ~STREAMS'(1);

  always_comb begin
    starved = '0;
    for (int n = 1; n < STREAMS; n++)
      starved[n] = i_inbound_valid[n] && (starve_cnt[n] >= STARVE_W'(STARVE_LIMIT));
  end

  // Starved sources beat source 0; the descending loop leaves the lowest index.
  always_comb begin
    sel      = rr_grant;
    sel_idx  = rr_idx;
    ptr_move = 1'b1;
    if (|starved) begin
      for (int n = STREAMS - 1; n >= 1; n--)
        if (starved[n]) begin
          sel     = STREAMS'(1) << n;
          sel_idx = PTR_W'(n);
        end
    end else if (i_inbound_valid[0]) begin
      sel      = STREAMS'(1);
      sel_idx  = '0;
      ptr_move = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      for (int n = 1; n < STREAMS; n++) starve_cnt[n] <= '0;
    end else begin
      for (int n = 1; n < STREAMS; n++) begin
        if (!i_inbound_valid[n] || grant[n])
          starve_cnt[n] <= '0;
        else if (load && starve_cnt[n] != '1)
          starve_cnt[n] <= starve_cnt[n] + 1'b1;
      end
    end
  end
`else
  assign rr_req   = i_inbound_valid;
  assign sel      = rr_grant;
  assign sel_idx  = rr_idx;
  assign ptr_move = 1'b1;
`endif

  assign load = !hold_valid || i_outbound_ready;
  // Gating with reset keeps a source from handing over a beat that reset would discard.
  assign grant     = (load && i_rst) ? sel : '0;
  assign any_grant = |grant;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      hold_valid <= 1'b0;
      hold_data  <= '0;
      rr_ptr     <= '0;
    end else if (load) begin
      hold_valid <= any_grant;
      if (any_grant) hold_data <= i_inbound_data[sel_idx];
      if (any_grant && ptr_move)
        rr_ptr <= (sel_idx == PTR_W'(STREAMS - 1)) ? '0 : sel_idx + 1'b1;
    end
  end

  assign o_inbound_ready  = grant;
  assign o_outbound_valid = hold_valid;
  assign o_outbound_data  = hold_data;
  assign o_idle           = !hold_valid && !(|i_inbound_valid);

endmodule

// File: tb/tb_nx_node_arbiter.sv
// Directed and randomised checks of nx_node_arbiter: a 4-source instance and
// a 3-source instance for pointer wrap.
module tb_nx_node_arbiter;
  import NXConstants::*;

  localparam int W = MESSAGE_WIDTH;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic [3:0]        valid4, ready4;
  logic [3:0][W-1:0] data4;
  logic [W-1:0]      odata4;
  logic              ovalid4, oready4, idle4;

  logic [2:0]        valid3, ready3;
  logic [2:0][W-1:0] data3;
  logic [W-1:0]      odata3;
  logic              ovalid3, oready3, idle3;

  int errors = 0;
  int checks = 0;
  logic [W-1:0] exp_q[$];

  nx_node_arbiter #(.STREAMS(4), .STARVE_LIMIT(4)) dut (
    .i_clk(clk), .i_rst(rst_n), .o_idle(idle4),
    .i_inbound_data(data4), .i_inbound_valid(valid4), .o_inbound_ready(ready4),
    .o_outbound_data(odata4), .o_outbound_valid(ovalid4), .i_outbound_ready(oready4)
  );

  nx_node_arbiter #(.STREAMS(3), .STARVE_LIMIT(4)) dut3 (
    .i_clk(clk), .i_rst(rst_n), .o_idle(idle3),
    .i_inbound_data(data3), .i_inbound_valid(valid3), .o_inbound_ready(ready3),
    .o_outbound_data(odata3), .o_outbound_valid(ovalid3), .i_outbound_ready(oready3)
  );

  // driver tasks
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [W-1:0] e;
    logic [3:0]   acc;
    int           seq;

    rst_n = 1'b0;
    valid4 = '0; data4 = '0; oready4 = 1'b0;
    valid3 = '0; data3 = '0; oready3 = 1'b0;

    #12;
    check("rst_valid", W'(ovalid4), 0);
    check("rst_data", odata4, 0);
    check("rst_ready", W'(ready4), 0);
    check("rst_idle", W'(idle4), 1);
    tick;
    rst_n = 1'b1;
    tick;

    // single source 2 carrying 0xA5
    data4[2] = 32'hA5; valid4 = 4'b0100; oready4 = 1'b1;
    #2;
    check("a5_ready", W'(ready4), 32'h4);
    check("a5_idle", W'(idle4), 0);
    tick;
    valid4 = '0;
    #2;
    check("a5_valid", W'(ovalid4), 1);
    check("a5_data", odata4, 32'hA5);
    tick;
    #2;
    check("drain_valid", W'(ovalid4), 0);
    check("drain_idle", W'(idle4), 1);

    // reset while a message is held
    for (int n = 0; n < 4; n++) data4[n] = 32'h100 + n;
    valid4 = 4'hF; oready4 = 1'b0;
    tick;
    check("mid_full", W'(ovalid4), 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", W'(ovalid4), 0);
    check("mid_rst_data", odata4, 0);
    check("mid_rst_ready", W'(ready4), 0);
    valid4 = '0;
    #1;
    check("mid_rst_idle", W'(idle4), 1);
    tick;
    rst_n = 1'b1;
    tick;

`ifndef NX_ARB_PRIORITY_EN
    // full contention: order 0,1,2,3,0 from reset
    begin
      int order[5] = '{0, 1, 2, 3, 0};
      for (int n = 0; n < 4; n++) data4[n] = 32'h100 + n;
      valid4 = 4'hF; oready4 = 1'b1;
      for (int i = 0; i < 5; i++) begin
        #2;
        check("rr_grant", W'(ready4), W'(1 << order[i]));
        e = data4[order[i]];
        tick;
        check("rr_valid", W'(ovalid4), 1);
        check("rr_data", odata4, e);
        data4[order[i]] = data4[order[i]] + 32'h10;
      end
    end

    // backpressure with register full, pointer at 1
    oready4 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #2;
      check("bp_ready", W'(ready4), 0);
      check("bp_data", odata4, e);
      check("bp_valid", W'(ovalid4), 1);
      check("bp_ptr", W'(dut.rr_ptr), 1);
      tick;
    end
    oready4 = 1'b1;
    #2;
    check("bp_resume1", W'(ready4), 32'h2);
    e = data4[1];
    tick;
    check("bp_resume1_data", odata4, e);
    data4[1] = data4[1] + 32'h10;
    #2;
    check("bp_resume2", W'(ready4), 32'h4);
    tick;
    valid4 = '0;
    tick;
    tick;

    // three sources: pointer wraps 2 -> 0
    begin
      logic [2:0] req[8] = '{3'b101, 3'b101, 3'b101, 3'b101, 3'b001, 3'b100, 3'b010, 3'b011};
      int         win[8] = '{0, 2, 0, 2, 0, 2, 1, 0};
      oready3 = 1'b1;
      for (int i = 0; i < 8; i++) begin
        valid3 = req[i];
        for (int n = 0; n < 3; n++) data3[n] = 32'h300 + i * 16 + n;
        #2;
        check("wrap_grant", W'(ready3), W'(1 << win[i]));
        e = 32'h300 + i * 16 + win[i];
        tick;
        check("wrap_data", odata3, e);
      end
      valid3 = '0;
      check("wrap_ptr", W'(dut3.rr_ptr), 1);
      tick;
    end
`else
    // source 0 always valid; source 1 wins on its fifth arbitration cycle
    begin
      int order[6] = '{0, 0, 0, 0, 1, 0};
      data4[0] = 32'h500; data4[1] = 32'h600;
      valid4 = 4'b0011; oready4 = 1'b1;
      for (int i = 0; i < 6; i++) begin
        #2;
        check("prio_grant", W'(ready4), W'(1 << order[i]));
        e = data4[order[i]];
        tick;
        check("prio_data", odata4, e);
        data4[order[i]] = data4[order[i]] + 32'h1;
      end
      valid4 = '0;
      tick;
      tick;
    end
`endif

    // random stress with scoreboard
    seq = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int n = 0; n < 4; n++)
        if (!valid4[n] && $urandom_range(0, 2) == 0) begin
          valid4[n] = 1'b1;
          data4[n]  = {8'(n), 24'(seq)};
          seq++;
        end
      oready4 = ($urandom_range(0, 3) != 0);
      #2;
      check("rnd_onehot", W'($onehot0(ready4)), 1);
      check("rnd_subset", W'(ready4 & ~valid4), 0);
      if (ovalid4 && !oready4) check("rnd_stall", W'(ready4), 0);
      if (ovalid4 && oready4) begin
        checks++;
        assert (exp_q.size() != 0) else begin
          errors++;
          $error("FAIL sb_extra: observed %0h expected none", odata4);
        end
        if (exp_q.size() != 0) check("sb_data", odata4, exp_q.pop_front());
      end
      acc = ready4;
      for (int n = 0; n < 4; n++)
        if (acc[n]) exp_q.push_back(data4[n]);
      tick;
      valid4 = valid4 & ~acc;
    end

    // drain remaining messages
    valid4 = '0; oready4 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #2;
      if (ovalid4 && exp_q.size() != 0) check("sb_drain", odata4, exp_q.pop_front());
      tick;
    end
    check("sb_left", W'(exp_q.size()), 0);
    check("end_valid", W'(ovalid4), 0);
    check("end_idle", W'(idle4), 1);

    // final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/nx_node_arbiter.md
# nx_node_arbiter

Shares a node's single outbound message path among several message sources (local core output, control responses, through-traffic) and presents one registered, valid/ready stream to the node's outbound distributor. Arbitration is round-robin at message granularity; each message is one beat of `node_message_t`. It sits directly upstream of the direction-routing distributor inside each mesh node.

## Interface
- `STREAMS`, 4: number of requesting sources; legal range 2..8, any value in range.
- `STARVE_LIMIT`, 8: consecutive lost cycles before a waiting source is forced to win; legal range 1..255. Used only with the priority feature.
- `i_clk` input 1: single clock; all state is on its rising edge.
- `i_rst` input 1: asynchronous, active-low reset.
- `o_idle` output 1: high when the holding register is empty and no `i_inbound_valid` bit is set.
- `i_inbound_data` input `[STREAMS][MESSAGE_WIDTH]`: message from each source.
- `i_inbound_valid` input `[STREAMS]`: per-source request.
- `o_inbound_ready` output `[STREAMS]`: per-source accept; at most one bit high (one-hot or zero).
- `o_outbound_data` output `MESSAGE_WIDTH`: registered winning message, as `node_message_t`.
- `o_outbound_valid` output 1: holding register occupied.
- `i_outbound_ready` input 1: downstream distributor accepts.

## Operation
- **Holding register.** One entry: data plus valid bit.
  - `load` = register empty, or (`o_outbound_valid` & `i_outbound_ready`).
- **Grant.**
  - When `load` is true and any valid bit is set, exactly one winner is selected combinationally.
  - `o_inbound_ready[winner]` = 1 in the same cycle.
  - The winner's data is captured at the clock edge, and `o_outbound_valid` is set.
  - When `load` is true but nothing is valid, the register empties if it was drained.
  - When `load` is false, all `o_inbound_ready` bits are 0.
- **Round-robin.**
  - Pointer `rr_ptr` has width `$clog2(STREAMS)`.
  - Search order: `rr_ptr`, `rr_ptr+1`, … wrapping modulo `STREAMS`, so non-power-of-2 counts are handled.
  - On each grant, `rr_ptr` = winner+1, wrapping `STREAMS-1` to 0.
  - `rr_ptr` is unchanged when there is no grant.
- **Source contract.**
  - Once raised, `i_inbound_valid[n]` and its data stay stable until `o_inbound_ready[n]`.
  - The arbiter never drops or duplicates a message.
- **Downstream contract.** `o_outbound_data` and `o_outbound_valid` are held stable while `o_outbound_valid` & !`i_outbound_ready`.
- **Throughput.** With `i_outbound_ready` held high, one message passes per cycle.
- **Reset.**
  - `o_outbound_valid`=0 and `o_outbound_data`=0.
  - All `o_inbound_ready`=0; `o_idle`=1.
  - `rr_ptr`=0 and all starvation counters=0.
  - Reset asserted mid-transfer discards the held message; sources must re-present after reset.

## Timing
- **Latency.** Accept to `o_outbound_valid` is 1 cycle.
- **Combinational paths.**
  - `o_inbound_ready` depends combinationally on `i_inbound_valid`, `i_outbound_ready`, and register state.
  - No combinational path from `i_inbound_data` to any output.
- **Simultaneous events.**
  - Drain and refill in the same cycle: the new message replaces the old one with no bubble.
  - All sources valid: grants rotate 0,1,2,3,0… starting from reset.
- **Stall.** With `i_outbound_ready`=0 and the register full, no grants, and `rr_ptr` and counters are frozen.
- **`o_idle`.** Combinational from the register valid bit and `i_inbound_valid`.

## Configuration
- **Macro `NX_ARB_PRIORITY_EN`.**
  - **Defined.** Source 0 has strict priority over the round-robin among sources 1..`STREAMS-1`.
    - Each source n≥1 has an 8-bit counter.
    - The counter increments when the source is valid, `load` is true, and it loses.
    - The counter clears when the source is granted or is not valid.
    - A source whose counter ≥ `STARVE_LIMIT` overrides source 0.
    - If several sources are starved, the lowest index wins.
    - Grants to source 0 do not move `rr_ptr`.
  - **Undefined.** Pure round-robin across all sources, no counters instantiated, and `STARVE_LIMIT` is ignored.

## Structure
- **Package.** `node_message_t` and `MESSAGE_WIDTH` come from `NXConstants`. No new package types are needed. The starvation counter width (8) is a localparam.
- **Sub-module `nx_arbiter_rr`.**
  - Parameterised `STREAMS`.
  - Inputs: request vector and pointer.
  - Outputs: one-hot grant and encoded index.
  - Purely combinational and reusable by other arbiters.
- **This block.** Holds the register, pointer, counters, and priority override.

## Test plan
- **Reset.** Assert `i_rst`=0 mid-stream → all outputs at reset values, `o_idle`=1. Release and present source 2 with 0xA5 → `o_outbound_data`=0xA5 one cycle later.
- **Full contention.** All 4 sources valid, `i_outbound_ready`=1 → grant order 0,1,2,3,0; one message per cycle, none lost.
- **Backpressure.** Hold `i_outbound_ready`=0 for 5 cycles with the register full → `o_outbound_data` stable, all `o_inbound_ready`=0, `rr_ptr` unchanged. Release → order resumes.
- **Pointer wrap.** `STREAMS`=3; sources 0 and 2 alternate valid → correct wrap 2→0, and the sequence matches a reference model.
- **Priority and starvation (`NX_ARB_PRIORITY_EN`, `STARVE_LIMIT`=4).** Source 0 always valid and source 1 valid → source 1 granted on its 5th arbitration cycle, then source 0 resumes.
- **Random stress.** Random valid/ready with a scoreboard → every message delivered exactly once, sources stable while waiting, `o_inbound_ready` never multi-hot.
